// File: rtl/mat44_vec4_seq_if.sv
// Operand/result handshake bundle for mat44_vec4_seq.
// Slave side is the engine, master side is the feeder/consumer.
interface mat44_vec4_seq_if;
   logic              in_valid;
   logic              in_ready;
   logic [15:0][15:0] mat_i;
   logic [3:0][15:0]  vec_i;
   logic              out_valid;
   logic              out_ready;
   logic [3:0][15:0]  vec_o;

   modport master (
      output in_valid,
      output mat_i,
      output vec_i,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  vec_o
   );

   modport slave (
      input  in_valid,
      input  mat_i,
      input  vec_i,
      input  out_ready,
      output in_ready,
      output out_valid,
      output vec_o
   );
endinterface

// File: rtl/mat44_vec4_seq.sv
// Transpose-times-vector engine: vec_o[c] = sum_r vec[r]*mat[4r+c].
// Define MAT44_VEC4_SEQ_SAT_EN to saturate outputs instead of wrapping.
module mat44_vec4_seq (
   input logic              clk,
   input logic              reset,
   mat44_vec4_seq_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      DONE
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [15:0][15:0] mat_q;
   logic [3:0][15:0]  vec_q;
   logic [3:0][33:0]  acc;
   logic [3:0][31:0]  prod;
   logic [1:0]        k;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state decode; accept only in IDLE, release only in DONE
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (bus.in_valid) state_nx = ACC;
         ACC:  if (k == 2'd3) state_nx = DONE;
         DONE: if (bus.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // One row of the matrix per cycle: row k scaled by vec[k]
   always_comb begin
      prod = '0;
      for (int c = 0; c < 4; c++) begin
         prod[c] = {16'd0, vec_q[k]} * {16'd0, mat_q[{k, 2'(c)}]};
      end
   end

   // Operand capture and accumulation
   always_ff @(posedge clk) begin
      if (reset) begin
         mat_q <= '0;
         vec_q <= '0;
         acc   <= '0;
         k     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  mat_q <= bus.mat_i;
                  vec_q <= bus.vec_i;
                  acc   <= '0;
                  k     <= '0;
               end
            end
            ACC: begin
               for (int c = 0; c < 4; c++) begin
                  acc[c] <= acc[c] + {2'b00, prod[c]};
               end
               k <= k + 2'd1;
            end
            default: ;
         endcase
      end
   end

   // Handshake flags and result, decoded from registered state only
   always_comb begin
      bus.in_ready  = (state == IDLE);
      bus.out_valid = (state == DONE);
      bus.vec_o     = '0;
      if (state == DONE) begin
         for (int c = 0; c < 4; c++) begin
`ifdef MAT44_VEC4_SEQ_SAT_EN
            bus.vec_o[c] = (acc[c] > 34'h0FFFF) ? 16'hFFFF
                                                : acc[c][15:0];
`else
            bus.vec_o[c] = acc[c][15:0];
`endif
         end
      end
   end

endmodule

// File: tb/tb_mat44_vec4_seq.sv
// Directed bench for mat44_vec4_seq.
// Expected vectors are hand-computed column sums.
module tb_mat44_vec4_seq;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   logic [15:0][15:0] m;
   logic [3:0][15:0]  v;
   logic [3:0][15:0]  e;
   logic [3:0][15:0]  e1;

   mat44_vec4_seq_if bus ();

   mat44_vec4_seq dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic apply();
      bus.mat_i = m;
      bus.vec_i = v;
   endtask

   task automatic scramble();
      for (int j = 0; j < 16; j++) bus.mat_i[j] = 16'($urandom);
      for (int j = 0; j < 4; j++) bus.vec_i[j] = 16'($urandom);
   endtask

   task automatic accept();
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("busy_in_ready", 64'(bus.in_ready), 64'd0);
   endtask

   task automatic wait_result(input string tag,
                              input logic [63:0] exp,
                              input bit scr);
      for (int i = 0; i < 3; i++) begin
         if (scr) scramble();
         @(posedge clk);
         #1;
         check({tag, "_lat"}, 64'(bus.out_valid), 64'd0);
         check({tag, "_zero"}, bus.vec_o, 64'd0);
      end
      if (scr) scramble();
      @(posedge clk);
      #1;
      check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, "_vec"}, bus.vec_o, exp);
   endtask

   task automatic take(input string tag);
      @(posedge clk);
      #1;
      check({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
      check({tag, "_nv"}, 64'(bus.out_valid), 64'd0);
      check({tag, "_vz"}, bus.vec_o, 64'd0);
   endtask

   initial begin
      clk           = 1'b0;
      reset         = 1'b1;
      errors        = 0;
      checks        = 0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.mat_i     = '0;
      bus.vec_i     = '0;

      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_vec_o", bus.vec_o, 64'd0);

      // Basic: mat[i] = i+1, vec = {1,2,3,4}
      for (int i = 0; i < 16; i++) m[i] = 16'(i + 1);
      v = {16'd4, 16'd3, 16'd2, 16'd1};
      e1 = {16'd120, 16'd110, 16'd100, 16'd90};
      apply();
      accept();
      wait_result("basic", e1, 1'b0);
      take("basic");

      // Identity passes the vector through
      m = '0;
      m[0] = 16'd1;
      m[5] = 16'd1;
      m[10] = 16'd1;
      m[15] = 16'd1;
      v = {16'hFFFF, 16'h0001, 16'hABCD, 16'h1234};
      apply();
      accept();
      wait_result("ident", v, 1'b0);
      take("ident");

      // Row vs column orientation
      m = '0;
      m[1] = 16'd2;
      v = {16'd0, 16'd0, 16'd0, 16'd5};
      e = {16'd0, 16'd0, 16'd10, 16'd0};
      apply();
      accept();
      wait_result("orient", e, 1'b0);
      take("orient");

      // Overflow: 4 * 0xFFFF^2
      m = '1;
      v = '1;
`ifdef MAT44_VEC4_SEQ_SAT_EN
      e = {4{16'hFFFF}};
`else
      e = {4{16'h0004}};
`endif
      apply();
      accept();
      wait_result("ovf", e, 1'b0);
      take("ovf");

      // Backpressure with a second request pending
      bus.out_ready = 1'b0;
      for (int i = 0; i < 16; i++) m[i] = 16'(i + 1);
      v = {16'd4, 16'd3, 16'd2, 16'd1};
      apply();
      accept();
      wait_result("bp1", e1, 1'b0);
      for (int i = 0; i < 16; i++) m[i] = 16'd1;
      apply();
      bus.in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
         check("bp_hold_vec", bus.vec_o, e1);
         check("bp_hold_rdy", 64'(bus.in_ready), 64'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_rel_rdy", 64'(bus.in_ready), 64'd1);
      check("bp_rel_nv", 64'(bus.out_valid), 64'd0);
      e = {4{16'd10}};
      accept();
      wait_result("bp2", e, 1'b0);
      take("bp2");

      // Reset during ACC with k = 2
      for (int i = 0; i < 16; i++) m[i] = 16'(i + 1);
      v = {16'd4, 16'd3, 16'd2, 16'd1};
      apply();
      accept();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("mid_rst_rdy", 64'(bus.in_ready), 64'd1);
      check("mid_rst_nv", 64'(bus.out_valid), 64'd0);
      check("mid_rst_vz", bus.vec_o, 64'd0);
      m = '0;
      m[1] = 16'd2;
      v = {16'd0, 16'd0, 16'd0, 16'd5};
      e = {16'd0, 16'd0, 16'd10, 16'd0};
      apply();
      accept();
      wait_result("post_rst", e, 1'b0);
      take("post_rst");

      // Operand capture: inputs churn after the accept edge
      for (int i = 0; i < 16; i++) m[i] = 16'(i + 1);
      v = {16'd4, 16'd3, 16'd2, 16'd1};
      apply();
      accept();
      wait_result("capture", e1, 1'b1);
      take("capture");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mat44_vec4_seq.md
# mat44_vec4_seq

Sequential matrix-transpose-times-vector engine: computes `vec_o[c] = Σ_r vec[r]·mat[4r+c]`, the column-direction product complementary to the existing row-dot-product vector/matrix path. Both paths use the same row-major 16-entry, 16-bit matrix layout. The block uses four 16×16 multipliers and accumulates one input-vector element per cycle, so a result takes four cycles. It sits in the transform pipeline behind a valid/ready handshake on both sides.

## Interface

Parameters:
- none (fixed 4×4, 16-bit unsigned)

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  upstream presents `mat_i` and `vec_i`
- `in_ready`  out  1  block can accept an operand set
- `mat_i`  in  16×16  matrix, row-major, `mat_i[4r+c]`
- `vec_i`  in  4×16  input vector
- `out_valid`  out  1  `vec_o` holds a finished result
- `out_ready`  in  1  downstream accepts the result
- `vec_o`  out  4×16  result vector

## Operation

- States: IDLE, ACC, DONE.
- Counter `k` is 2 bits.
- Accumulators `acc[0..3]` are 34 bits each (4 × 32-bit products).

IDLE:
- `in_ready` = 1.
- On `in_valid && in_ready`:
  - register `mat_i` and `vec_i` into internal copies;
  - clear all `acc`;
  - set `k` = 0;
  - go to ACC.
- Upstream may change its inputs freely after the handshake.

ACC, each cycle:
- `acc[c] += vec[k]·mat[4k+c]` for c = 0..3, using full 32-bit products and exact 34-bit sums.
- `k` increments.
- After the edge with `k` = 3, go to DONE.

DONE:
- `out_valid` = 1.
- `vec_o[c]` = result of `acc[c]` per the Configuration section.
- Holds stable while `out_ready` = 0.
- On `out_ready` = 1, go to IDLE.

Outputs outside DONE:
- `vec_o` = 0 and `out_valid` = 0.
- `in_ready` = 1 only in IDLE. There is no accept while in ACC or DONE.

Arithmetic:
- All operands unsigned.
- Without saturation, the output is the low 16 bits of the exact sum, i.e. modulo 2^16.

Reset:
- Any cycle with `reset` = 1 forces IDLE on that edge, clears `acc`, `k` and the operand copies, and ignores `in_valid`/`out_ready`.
- Reset mid-ACC or mid-DONE discards the result; no `out_valid` is emitted for it.
- Reset values: `in_ready` = 1, `out_valid` = 0, `vec_o` = all 0.

## Timing

- Handshake accepted at edge T.
- Accumulations at edges T+1 … T+4.
- `out_valid` high in the cycle after edge T+4, i.e. 4 cycles after the accept cycle.
- Result taken at edge U (`out_valid && out_ready`). `in_ready` high in the cycle after U.
- Best-case throughput: one operation per 6 cycles.
- `in_ready` and `out_valid` are decoded purely from registered state, with no combinational path from `in_valid`/`out_ready`.

## Configuration

`MAT44_VEC4_SEQ_SAT_EN`:
- Defined: `vec_o[c]` = `acc[c]` > 0xFFFF ? 0xFFFF : `acc[c][15:0]` (unsigned saturation).
- Undefined: `vec_o[c]` = `acc[c][15:0]` (wrap).
- Datapath, latency and handshake are identical in both builds.

## Test plan

- Basic values: `mat[i]` = i+1, `vec` = {1,2,3,4}, `out_ready` = 1 → `out_valid` 4 cycles after accept, `vec_o` = {90,100,110,120}.
- Identity matrix with `vec` = {0x1234, 0xABCD, 0x0001, 0xFFFF} → `vec_o` equals `vec`. Then a row-vs-column check: a matrix with `mat[1]` = 2 and all other entries 0, `vec` = {5,0,0,0} → `vec_o` = {0,10,0,0}.
- Overflow: all `mat` and `vec` entries = 0xFFFF.
  - Without the macro → every `vec_o` = 0x0004.
  - With `MAT44_VEC4_SEQ_SAT_EN` → every `vec_o` = 0xFFFF.
- Backpressure: hold `out_ready` = 0 for 10 cycles in DONE.
  - `vec_o` stays stable, `in_ready` = 0, a new `in_valid` is not accepted.
  - Release `out_ready` → `in_ready` = 1 the next cycle and the second operation completes correctly.
- Reset: assert `reset` for 1 cycle during ACC (`k` = 2).
  - Next cycle: `in_ready` = 1, `out_valid` = 0, `vec_o` = 0.
  - A fresh operation then yields correct results with no leftover accumulation.
- Operand capture: change `mat_i`/`vec_i` every cycle after the accept → the result reflects only the values captured at the accept edge.
